// File: rtl/alu_pkg.sv
// Shared widths and command layout for the ALU issue path.
// Anything that talks to ALU_UNIT (wrappers, benches) pulls its types from here.
package alu_pkg;

  localparam int OP_W  = 4;
  localparam int SEL_W = 4;
  localparam int RES_W = 8;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [SEL_W-1:0] sel;
    logic [OP_W-1:0]  b;
    logic [OP_W-1:0]  a;
  } cmd_t;

  // Flat width of a command word laid out as {tag, sel, b, a}.
  function automatic int cmd_w(input int op_w, input int sel_w, input int tag_w);
    return 2 * op_w + sel_w + tag_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO whose head word is a register, zeroed whenever the FIFO is empty,
// so downstream combinational logic sees clean, glitch-free operands.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic [WIDTH-1:0] rd_data_reg, rd_data_next;
  logic             push_ok, pop_ok;

  assign full    = (level_reg == LVL_W'(DEPTH));
  assign empty   = (level_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    rd_ptr_next = pop_ok ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    level_next  = level_reg;
    case ({push_ok, pop_ok})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
    // Look ahead to the word that will be at the head after this edge; a lone
    // entry being written right now has to bypass the array.
    rd_data_next = mem[rd_ptr_next];
    if (level_next == '0) begin
      rd_data_next = '0;
    end else if (push_ok && level_next == LVL_W'(1)) begin
      rd_data_next = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg  <= rd_ptr_next;
      level_reg   <= level_next;
      rd_data_reg <= rd_data_next;
    end
  end

  assign rd_data = rd_data_reg;
  assign level   = level_reg;

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of ALU_UNIT: queues tagged commands, presents the head to the
// ALU and captures its result into a valid/ready output register.
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int OP_W  = alu_pkg::OP_W,
  parameter int SEL_W = alu_pkg::SEL_W,
  parameter int RES_W = alu_pkg::RES_W,
  parameter int TAG_W = alu_pkg::TAG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        in_a,
  input  logic [OP_W-1:0]        in_b,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [OP_W-1:0]        alu_a,
  output logic [OP_W-1:0]        alu_b,
  output logic [SEL_W-1:0]       alu_sel,
  input  logic [RES_W-1:0]       alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RES_W-1:0]       out_result,
  output logic [SEL_W-1:0]       out_sel,
  output logic [TAG_W-1:0]       out_tag,
  output logic [$clog2(DEPTH):0] level
);

  import alu_pkg::*;

  localparam int CMD_W = cmd_w(OP_W, SEL_W, TAG_W);
  localparam int SEL_LO = 2 * OP_W;
  localparam int TAG_LO = 2 * OP_W + SEL_W;

  logic [TAG_W-1:0] tag_reg;
  logic [CMD_W-1:0] wr_cmd, head;
  logic             fifo_full, fifo_empty;
  logic             push, cap;
  logic             out_valid_reg;
  logic [RES_W-1:0] out_result_reg;
  logic [SEL_W-1:0] out_sel_reg;
  logic [TAG_W-1:0] out_tag_reg;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign wr_cmd   = {tag_reg, in_sel, in_b, in_a};
  // The output register can take a new result when empty or when it drains this cycle.
  assign cap      = !fifo_empty && (!out_valid_reg || out_ready);

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_cmd),
    .pop     (cap),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // Head register reads as zero when empty, so the ALU inputs idle at 0.
  assign alu_a   = head[OP_W-1:0];
  assign alu_b   = head[SEL_LO-1:OP_W];
  assign alu_sel = head[TAG_LO-1:SEL_LO];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      out_sel_reg    <= '0;
      out_tag_reg    <= '0;
    end else begin
      if (push) begin
        tag_reg <= tag_reg + 1'b1;
      end
      if (cap) begin
        out_valid_reg  <= 1'b1;
        out_result_reg <= alu_result;
        out_sel_reg    <= head[TAG_LO-1:SEL_LO];
        out_tag_reg    <= head[CMD_W-1:TAG_LO];
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign out_sel    = out_sel_reg;
  assign out_tag    = out_tag_reg;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Sequential stage directly upstream of the combinational ALU_UNIT (4-bit a/b, 4-bit sel, 8-bit result).
- Buffers operation commands (a, b, sel) in a small FIFO and drives the head command onto the ALU inputs.
- Captures the ALU result into an output register.
- Exposes valid/ready handshakes on both sides, so producers and consumers can stall independently.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >=2)
- OP_W, 4, operand width for a and b
- SEL_W, 4, opcode width
- RES_W, 8, ALU result width
- TAG_W, 4, sequence tag width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  command present
- in_ready  output  1  stage can accept a command
- in_a  input  OP_W  operand a
- in_b  input  OP_W  operand b
- in_sel  input  SEL_W  opcode
- alu_a  output  OP_W  to ALU_UNIT.a
- alu_b  output  OP_W  to ALU_UNIT.b
- alu_sel  output  SEL_W  to ALU_UNIT.sel
- alu_result  input  RES_W  from ALU_UNIT.result (combinational)
- out_valid  output  1  output register holds a result
- out_ready  input  1  consumer accepts the result
- out_result  output  RES_W  captured result
- out_sel  output  SEL_W  opcode that produced out_result
- out_tag  output  TAG_W  sequence number of the command, in acceptance order
- level  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (async, active-high):
  - FIFO empty, level=0; read/write pointers and tag counter cleared to 0.
  - out_valid=0, out_result=0, out_sel=0, out_tag=0.
  - alu_a/alu_b/alu_sel=0.
  - Reset asserted mid-operation flushes all buffered and in-flight commands; no output is produced for them.
- Push: on the edge where in_valid && in_ready, the command is written at the write pointer.
  - The entry also stores tag = tag counter. The tag counter then increments mod 2^TAG_W (15 -> 0).
- in_ready = (level != DEPTH). There is no bypass when full, even if a pop occurs in the same cycle.
- ALU drive: when level>0, alu_a/alu_b/alu_sel come from the FIFO head registers (registered, glitch-free). When level==0 they are driven to 0.
- Capture condition: cap = (level>0) && (!out_valid || out_ready).
  - On the edge where cap is true: out_result<=alu_result, out_sel<=head sel, out_tag<=head tag, out_valid<=1, and the head is popped.
- Drain without refill: if out_valid && out_ready && !cap, then out_valid<=0. out_result, out_sel and out_tag hold their values.
- Latency: a command accepted at edge N is captured no earlier than edge N+1 (out_valid high after N+1). Sustained throughput is 1 result per cycle when out_ready=1.
- Occupancy: simultaneous push and pop leaves level unchanged. Pointers wrap modulo DEPTH.
- Ordering: results leave in strict acceptance order. out_tag is consecutive mod 2^TAG_W.
- Total stage capacity is DEPTH+1 (FIFO plus output register).
- Stall: while out_valid && !out_ready, out_result, out_sel and out_tag are stable and the FIFO does not pop.
- No width conversion: the result is passed through unchanged at RES_W bits.
- State summary, per the output register:
  - EMPTY (out_valid=0) -> FULL on cap.
  - FULL -> FULL on cap (replace).
  - FULL -> EMPTY on out_ready && !cap.

Decomposition:
- Shared package alu_pkg:
  - OP_W, SEL_W, RES_W, TAG_W constants.
  - Command struct typedef {a, b, sel, tag}, reused by ALU_UNIT wrappers and benches.
- Sub-module sync_fifo (parameterised width/depth, push/pop, full/empty, level) holds the command queue.
- alu_issue_stage contains sync_fifo, the output register and the cap logic. ALU_UNIT is instantiated alongside at the parent level, not inside this block.

Test Plan:
- Reset check: assert rst for 2 cycles with in_valid=1 -> level=0, out_valid=0, in_ready=1, alu_a/alu_b/alu_sel=0 throughout.
- Single op: push a=2, b=3, sel=0 at edge N, out_ready=1 -> out_valid rises after edge N+1. out_result equals the reference ALU model for (2,3,0), out_sel=0, out_tag=0.
- Opcode sweep: push a=2, b=3 with sel=0..15 back-to-back, out_ready=1 -> 16 results with sel 0..15 and tags 0..15 in order. One result per cycle after first latency. Each result matches the model.
- Backpressure: out_ready=0, offer 7 commands -> exactly 5 accepted (1 in output register, level=4) and in_ready=0. The output stays at tag 0. Raising out_ready drains tags 0..4 in order.
- Full with simultaneous pop: level=4 and out_ready=1 with in_valid=1 -> the push is refused that cycle (in_ready=0). The next cycle level=3, in_ready=1 and the push is accepted.
- Mid-operation reset plus tag wrap: push 18 commands, assert rst after 10 -> all outputs clear. Post-reset tags restart at 0. A separate run of 17 pushes shows tag 15 followed by 0.
